card_turn_controller: RTL
=========================

# card_turn_controller

Turn sequencer for the 4x4 memory-card game. Accepts card selections from the input layer and owns the per-card face-up and matched state bits that the VGA renderer reads, replacing a static state matrix. Compares the two flipped card values, holds a mismatch on screen for a configurable time, and keeps score. Sits between the button/cursor logic and the card drawing logic.

## Interface
- SHOW_CYCLES, default 50_000_000: cycles a mismatched pair stays face-up (≥1).
- VAL_W, default 3: width of a card value (pair identifier).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- new_game  in  1  single-cycle pulse; same effect as rst, sampled on clk.
- sel_valid  in  1  a selection is presented this cycle.
- sel_row  in  2  row of selected card.
- sel_col  in  2  column of selected card.
- val_addr  out  4  card index = sel_row*4 + sel_col (combinational from sel_row/sel_col).
- val_data  in  VAL_W  card value at val_addr, valid in the same cycle.
- sel_ack  out  1  one-cycle pulse: selection accepted.
- face_up  out  16  bit i = card i currently shown as a temporary flip.
- matched  out  16  bit i = card i permanently matched.
- player  out  1  current player (0 or 1).
- score0  out  4  pairs found by player 0.
- score1  out  4  pairs found by player 1.
- busy  out  1  high in COMPARE and SHOW.
- game_over  out  1  high in DONE.

## Operation
- States: FIRST, SECOND, COMPARE, SHOW, DONE. Reset state FIRST.
- Accept condition: state is FIRST or SECOND, sel_valid=1, face_up[idx]=0, and matched[idx]=0. Otherwise the selection is dropped and sel_ack stays 0.
- FIRST, accept: set face_up[idx], latch idx and val_data into the A registers, and go to SECOND.
- SECOND, accept: set face_up[idx], latch into the B registers, and go to COMPARE.
- COMPARE: one cycle. Values compare as equal when valA == valB.
  - Equal: set matched[idxA] and matched[idxB], clear both face_up bits, and increment the current player's score. Go to DONE if matched becomes all ones, else to FIRST. Player is unchanged.
  - Unequal: load the hold counter with SHOW_CYCLES-1 and go to SHOW.
- SHOW: decrement the counter each cycle. In the cycle it reads 0, clear face_up[idxA] and face_up[idxB], toggle player, and go to FIRST.
- DONE: all selections are ignored. Leaves only via rst or new_game.
- Scores are 4 bits wide and saturate at 8; 8 pairs exist in total.
- rst or new_game in any state, including mid-SHOW: return to FIRST; clear face_up, matched, scores, player, and counter. rst takes priority over all other events in that cycle.

## Timing
- Reset values: face_up=0, matched=0, player=0, score0=0, score1=0, sel_ack=0, busy=0, game_over=0.
- sel_ack is registered. It is high in the cycle after the accepting edge, in the same cycle the face_up bit is first visible.
- Second accept at edge N: COMPARE occupies cycle N+1. The match result (matched bits, score) is visible after edge N+2.
- Mismatch: both face_up bits remain set for exactly SHOW_CYCLES cycles after COMPARE. The clear and player toggle are visible after edge N+2+SHOW_CYCLES.
- A sel_valid held high across several cycles is re-evaluated each cycle. The same card cannot be double-accepted because its face_up bit is already set.

## Configuration
- TWO_PLAYER_EN defined: behaviour as described above. The player toggles on mismatch, and score1 is live.
- TWO_PLAYER_EN undefined: player is tied to 0 and never toggles. score1 is tied to 0, and all pairs credit score0.

## Test plan
- Matching pair, SHOW_CYCLES=4, values: card 0=3, card 5=3. Select (0,0), then (1,1) → sel_ack twice; matched=0x0021, face_up=0, score0=1, player=0, and no SHOW cycles occur.
- Mismatch, SHOW_CYCLES=4: card 0=1, card 1=2. Select both → face_up=0x0003 for exactly 4 cycles with busy=1, then face_up=0 and player=1 (0 without TWO_PLAYER_EN).
- Invalid selects: select (0,0), then (0,0) again → second sel_ack=0, state stays SECOND. Selecting an already-matched card → ignored. sel_valid during SHOW → ignored.
- Full game: play all 8 matching pairs → matched=0xFFFF, game_over=1, score0+score1=8; any later selects are ignored.
- Reset mid-SHOW: assert rst at SHOW cycle 2 → next cycle face_up=0, matched=0, scores=0, player=0, state FIRST. Repeat using new_game and check the same result.

Source files
------------

// File: rtl/card_turn_controller.sv
// -----------------------------------------------------------------------------
// card_turn_controller
//
// Turn sequencer for the 4x4 memory-card game. Takes card selections from the
// button/cursor layer, owns the per-card face-up and matched bits read by the
// VGA renderer, compares each flipped pair, holds a mismatched pair on screen
// for SHOW_CYCLES cycles, and keeps score.
//
// Configuration macro: TWO_PLAYER_EN
//   defined   : the player toggles after every mismatch; score1 is live.
//   undefined : player stays 0, score1 stays 0, every pair credits score0.
//
// Parameters
//   SHOW_CYCLES : cycles a mismatched pair stays face-up after COMPARE (>= 1)
//   VAL_W       : width of a card value (pair identifier)
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   new_game   in   single-cycle pulse, same effect as rst
//   sel_valid  in   a selection is presented this cycle
//   sel_row    in   row of the selected card
//   sel_col    in   column of the selected card
//   val_addr   out  card index sel_row*4 + sel_col (combinational)
//   val_data   in   card value at val_addr, valid in the same cycle
//   sel_ack    out  registered one-cycle pulse: selection accepted
//   face_up    out  bit i = card i shown as a temporary flip
//   matched    out  bit i = card i permanently matched
//   player     out  current player
//   score0     out  pairs found by player 0 (saturates at 8)
//   score1     out  pairs found by player 1 (saturates at 8)
//   busy       out  high in COMPARE and SHOW
//   game_over  out  high in DONE
// -----------------------------------------------------------------------------
module card_turn_controller #(
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int VAL_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic             sel_valid,
  input  logic [1:0]       sel_row,
  input  logic [1:0]       sel_col,
  output logic [3:0]       val_addr,
  input  logic [VAL_W-1:0] val_data,
  output logic             sel_ack,
  output logic [15:0]      face_up,
  output logic [15:0]      matched,
  output logic             player,
  output logic [3:0]       score0,
  output logic [3:0]       score1,
  output logic             busy,
  output logic             game_over
);

  // The hold counter only ever holds SHOW_CYCLES-1 down to 0.
  localparam int               CNT_W     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [3:0]       SCORE_MAX = 4'd8;

  typedef enum logic [2:0] {
    ST_FIRST,
    ST_SECOND,
    ST_COMPARE,
    ST_SHOW,
    ST_DONE
  } state_t;

  state_t           state, state_next;
  logic [15:0]      face_up_next, matched_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       score0_q, score0_next;
  logic [3:0]       score1_q, score1_next;
  logic             player_q, player_next;
  logic             ack_next;
  logic             load_a, load_b;
  logic [3:0]       idx_a, idx_b;
  logic [VAL_W-1:0] val_a, val_b;
  logic [3:0]       sel_idx;
  logic             accept;

  assign sel_idx  = {sel_row, sel_col};
  assign val_addr = sel_idx;

  // A card already showing or already matched can never be taken again, which
  // also stops a held sel_valid from accepting the same card twice.
  assign accept = sel_valid && ((state == ST_FIRST) || (state == ST_SECOND)) &&
                  !face_up[sel_idx] && !matched[sel_idx];

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? s : s + 4'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and datapath-next logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next   = state;
    face_up_next = face_up;
    matched_next = matched;
    cnt_next     = cnt;
    score0_next  = score0_q;
    score1_next  = score1_q;
    player_next  = player_q;
    ack_next     = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    busy         = 1'b0;
    game_over    = 1'b0;

    case (state)
      ST_FIRST: begin
        if (accept) begin
          face_up_next[sel_idx] = 1'b1;
          load_a                = 1'b1;
          ack_next              = 1'b1;
          state_next            = ST_SECOND;
        end
      end

      ST_SECOND: begin
        if (accept) begin
          face_up_next[sel_idx] = 1'b1;
          load_b                = 1'b1;
          ack_next              = 1'b1;
          state_next            = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        busy = 1'b1;
        if (val_a == val_b) begin
          matched_next[idx_a] = 1'b1;
          matched_next[idx_b] = 1'b1;
          face_up_next[idx_a] = 1'b0;
          face_up_next[idx_b] = 1'b0;
`ifdef TWO_PLAYER_EN
          if (player_q) score1_next = sat_inc(score1_q);
          else          score0_next = sat_inc(score0_q);
`else
          score0_next = sat_inc(score0_q);
`endif
          state_next = (matched_next == 16'hFFFF) ? ST_DONE : ST_FIRST;
        end else begin
          cnt_next   = SHOW_LOAD;
          state_next = ST_SHOW;
        end
      end

      ST_SHOW: begin
        busy = 1'b1;
        // The cycle that reads 0 is the last of SHOW_CYCLES hold cycles.
        if (cnt == '0) begin
          face_up_next[idx_a] = 1'b0;
          face_up_next[idx_b] = 1'b0;
`ifdef TWO_PLAYER_EN
          player_next = ~player_q;
`endif
          state_next = ST_FIRST;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      ST_DONE: begin
        game_over = 1'b1;
      end

      default: state_next = ST_FIRST;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. rst and new_game have identical effect, so rst's priority
  // over every other event in the cycle falls out of this single branch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || new_game) begin
      state    <= ST_FIRST;
      face_up  <= '0;
      matched  <= '0;
      cnt      <= '0;
      score0_q <= '0;
      score1_q <= '0;
      player_q <= 1'b0;
      sel_ack  <= 1'b0;
    end else begin
      state    <= state_next;
      face_up  <= face_up_next;
      matched  <= matched_next;
      cnt      <= cnt_next;
      score0_q <= score0_next;
      score1_q <= score1_next;
      player_q <= player_next;
      sel_ack  <= ack_next;
    end
  end

  // NOTE: the pair capture registers carry no reset; they are always written
  // by an accept before COMPARE or SHOW can read them.
  always_ff @(posedge clk) begin
    if (load_a) begin
      idx_a <= sel_idx;
      val_a <= val_data;
    end
    if (load_b) begin
      idx_b <= sel_idx;
      val_b <= val_data;
    end
  end

  // In the single-player build player_q and score1_q never leave their reset
  // value of 0, so these outputs are constant zero.
  assign player = player_q;
  assign score0 = score0_q;
  assign score1 = score1_q;

endmodule
